// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver FSM encoding and baud divider sizing.
// Used by both uart_rx_ovs and uart_tx.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_BRK_WAIT
  } rx_state_e;

  // Clocks per oversample tick: truncating division, never below 1.
  function automatic int tick_div(input int clk_hz, input int bit_rate, input int oversample);
    int div;
    div = clk_hz / (bit_rate * oversample);
    return (div < 1) ? 1 : div;
  endfunction

  // odd_ones is the XOR of the data bits and the received parity bit.
  function automatic logic parity_error(input int mode, input logic odd_ones);
    case (mode)
      PAR_ODD:  return ~odd_ones;
      PAR_EVEN: return odd_ones;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_ovs_if.sv
// Receiver-side bundle: line input, enable and the held valid/ready output word with its flags.
// master = the receiver, slave = the consumer that drives the pin and accepts words.
interface uart_rx_ovs_if #(
  parameter int PAYLOAD_BITS = 8
);
  logic                    uart_rxd;
  logic                    rx_en;
  logic [PAYLOAD_BITS-1:0] rx_data;
  logic                    rx_valid;
  logic                    rx_ready;
  logic                    rx_parity_err;
  logic                    rx_frame_err;
  logic                    rx_break;
  logic                    rx_overrun;

  modport master (
    input  uart_rxd, rx_en, rx_ready,
    output rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_break, rx_overrun
  );

  modport slave (
    output uart_rxd, rx_en, rx_ready,
    input  rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_break, rx_overrun
  );
endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clock tick every TICK_DIV clocks, restartable so the
// receiver can align its sampling grid to a start edge.
module uart_baud_tick #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);
  localparam int            CW       = $clog2(TICK_DIV + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: cnt_d gets a value on every path before any condition, so no latch is inferred.
    cnt_d = cnt_q + CW'(1);
    if (restart || cnt_q == CNT_LAST) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking, so every flop in the design samples pre-edge values.
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == CNT_LAST);
endmodule

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver: 3-sample majority per bit, optional parity, 1/2 stop bits,
// parity/framing/break/overrun reporting and a held valid/ready output register.
module uart_rx_ovs
  import uart_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BIT_RATE     = 9600,
  parameter int PAYLOAD_BITS = 8,
  parameter int PARITY       = PAR_NONE,
  parameter int STOP_BITS    = 1,
  parameter int OVERSAMPLE   = 16
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_ovs_if.master bus
);
  localparam int TICK_DIV = tick_div(CLK_HZ, BIT_RATE, OVERSAMPLE);
  localparam int S_W      = $clog2(OVERSAMPLE);
  localparam int BC_W     = $clog2(PAYLOAD_BITS + 1);

  localparam logic [S_W-1:0]  S_SMP0       = S_W'(OVERSAMPLE / 2 - 1);
  localparam logic [S_W-1:0]  S_SMP1       = S_W'(OVERSAMPLE / 2);
  localparam logic [S_W-1:0]  S_DEC        = S_W'(OVERSAMPLE / 2 + 1);
  localparam logic [S_W-1:0]  S_LAST       = S_W'(OVERSAMPLE - 1);
  localparam logic [BC_W-1:0] BC_DATA_LAST = BC_W'(PAYLOAD_BITS);
  localparam logic [BC_W-1:0] BC_STOP_LAST = BC_W'(STOP_BITS - 1);

  logic rxd_meta_q, rxd_s_q;

  rx_state_e                state_q, state_d;
  logic [S_W-1:0]           s_q, s_d;
  logic [BC_W-1:0]          bit_cnt_q, bit_cnt_d;
  logic [PAYLOAD_BITS-1:0]  shreg_q, shreg_d;
  logic [1:0]               smp_q, smp_d;
  logic                     zero_q, zero_d;
  logic                     par_err_q, par_err_d;
  logic                     frame_err_q, frame_err_d;

  logic [PAYLOAD_BITS-1:0]  rx_data_q, rx_data_d;
  logic                     rx_valid_q, rx_valid_d;
  logic                     rx_parity_err_q, rx_parity_err_d;
  logic                     rx_frame_err_q, rx_frame_err_d;
  logic                     rx_break_q, rx_break_d;
  logic                     rx_overrun_q, rx_overrun_d;

  logic tick, restart, decide, wrap, bit_val;
  logic done, done_frame, done_brk;

  assign restart = (state_q == RX_IDLE) && !rxd_s_q;

  uart_baud_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick    (tick)
  );

  assign decide  = tick && (s_q == S_DEC);
  assign wrap    = tick && (s_q == S_LAST);
  assign bit_val = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxd_s_q) | (smp_q[1] & rxd_s_q);

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    smp_d       = smp_q;
    zero_d      = zero_q;
    par_err_d   = par_err_q;
    frame_err_d = frame_err_q;
    done        = 1'b0;
    done_frame  = 1'b0;
    done_brk    = 1'b0;

    if (tick && state_q != RX_IDLE && state_q != RX_BRK_WAIT) begin
      s_d = (s_q == S_LAST) ? '0 : s_q + S_W'(1);
      if (s_q == S_SMP0) smp_d[0] = rxd_s_q;
      if (s_q == S_SMP1) smp_d[1] = rxd_s_q;
    end

    unique case (state_q)
      RX_IDLE: begin
        s_d = '0;
        if (!rxd_s_q && bus.rx_en) begin
          state_d     = RX_START;
          bit_cnt_d   = '0;
          zero_d      = 1'b1;
          par_err_d   = 1'b0;
          frame_err_d = 1'b0;
        end
      end
      RX_START: begin
        if (decide && bit_val) state_d = RX_IDLE;
        else if (wrap)         state_d = RX_DATA;
      end
      RX_DATA: begin
        if (decide) begin
          shreg_d   = {bit_val, shreg_q[PAYLOAD_BITS-1:1]};
          zero_d    = zero_q & ~bit_val;
          bit_cnt_d = bit_cnt_q + BC_W'(1);
        end
        if (wrap && bit_cnt_q == BC_DATA_LAST) begin
          bit_cnt_d = '0;
          state_d   = (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
        end
      end
      RX_PARITY: begin
        if (decide) begin
          par_err_d = parity_error(PARITY, ^shreg_q ^ bit_val);
          zero_d    = zero_q & ~bit_val;
        end
        if (wrap) state_d = RX_STOP;
      end
      RX_STOP: begin
        if (decide) begin
          frame_err_d = frame_err_q | ~bit_val;
          zero_d      = zero_q & ~bit_val;
          bit_cnt_d   = bit_cnt_q + BC_W'(1);
          // The frame ends mid-way through the last stop bit so a back-to-back start edge is seen.
          if (bit_cnt_q == BC_STOP_LAST) begin
            done       = 1'b1;
            done_frame = frame_err_q | ~bit_val;
            done_brk   = zero_q & ~bit_val;
            state_d    = done_brk ? RX_BRK_WAIT : RX_IDLE;
          end
        end
      end
      RX_BRK_WAIT: begin
        if (rxd_s_q) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_data_d       = rx_data_q;
    rx_valid_d      = rx_valid_q;
    rx_parity_err_d = rx_parity_err_q;
    rx_frame_err_d  = rx_frame_err_q;
    rx_break_d      = rx_break_q;
    rx_overrun_d    = 1'b0;

    if (done) begin
      // An accept on the completion clock frees the register for the new word.
      if (!rx_valid_q || bus.rx_ready) begin
        rx_data_d       = shreg_q;
        rx_parity_err_d = par_err_q;
        rx_frame_err_d  = done_frame;
        rx_break_d      = done_brk;
        rx_valid_d      = 1'b1;
      end else begin
        rx_overrun_d = 1'b1;
      end
    end else if (rx_valid_q && bus.rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // Synchroniser resets to the idle line level so reset release never looks like a start edge.
      rxd_meta_q      <= 1'b1;
      rxd_s_q         <= 1'b1;
      state_q         <= RX_IDLE;
      s_q             <= '0;
      bit_cnt_q       <= '0;
      shreg_q         <= '0;
      smp_q           <= '0;
      zero_q          <= 1'b0;
      par_err_q       <= 1'b0;
      frame_err_q     <= 1'b0;
      rx_data_q       <= '0;
      rx_valid_q      <= 1'b0;
      rx_parity_err_q <= 1'b0;
      rx_frame_err_q  <= 1'b0;
      rx_break_q      <= 1'b0;
      rx_overrun_q    <= 1'b0;
    end else begin
      rxd_meta_q      <= bus.uart_rxd;
      rxd_s_q         <= rxd_meta_q;
      state_q         <= state_d;
      s_q             <= s_d;
      bit_cnt_q       <= bit_cnt_d;
      shreg_q         <= shreg_d;
      smp_q           <= smp_d;
      zero_q          <= zero_d;
      par_err_q       <= par_err_d;
      frame_err_q     <= frame_err_d;
      rx_data_q       <= rx_data_d;
      rx_valid_q      <= rx_valid_d;
      rx_parity_err_q <= rx_parity_err_d;
      rx_frame_err_q  <= rx_frame_err_d;
      rx_break_q      <= rx_break_d;
      rx_overrun_q    <= rx_overrun_d;
    end
  end

  assign bus.rx_data       = rx_data_q;
  assign bus.rx_valid      = rx_valid_q;
  assign bus.rx_parity_err = rx_parity_err_q;
  assign bus.rx_frame_err  = rx_frame_err_q;
  assign bus.rx_break      = rx_break_q;
  assign bus.rx_overrun    = rx_overrun_q;
endmodule
